// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard and forwarding controller for the five-stage pipeline.
// Tracks EX/MEM/WB destinations, selects operand bypasses, and handles load-use stalls.
module ex_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  input  logic                  dmem_busy,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall_if_id,
  output logic                  ex_bubble,
  output logic                  ex_valid,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_t;

  typedef struct packed {
    stage_t                base;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
  } ex_stage_t;

  ex_stage_t        ex_q, ex_d;
  stage_t           mem_q, mem_d;
  stage_t           wb_q;
  logic [CNT_W-1:0] stall_count_q;

  logic lu;
  logic rs1_hit;
  logic rs2_hit;
  logic count_en;

  // Load-use: the load in EX cannot bypass its data until it reaches WB.
  always_comb begin
    rs1_hit  = id_use_rs1 && (ex_q.base.rd == id_rs1);
    rs2_hit  = id_use_rs2 && (ex_q.base.rd == id_rs2);
    lu       = id_valid && ex_q.base.valid && ex_q.base.mem_read &&
               (ex_q.base.rd != '0) && (rs1_hit || rs2_hit);
    count_en = lu && !flush && !dmem_busy;
  end

  always_comb begin
    stall_if_id = dmem_busy || (lu && !flush);
    ex_bubble   = !dmem_busy && (flush || lu);
    ex_valid    = ex_q.base.valid;
    stall_count = stall_count_q;
  end

  // MEM is checked first because it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(input logic                  src_used,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input logic                  ex_live,
                                         input stage_t                mem,
                                         input stage_t                wb);
    logic [1:0] sel;
    sel = FwdRf;
    if (src_used && ex_live) begin
      if (mem.valid && mem.reg_write && !mem.mem_read && (mem.rd != '0) && (mem.rd == src)) begin
        sel = FwdMem;
      end else if (wb.valid && wb.reg_write && (wb.rd != '0) && (wb.rd == src)) begin
        sel = FwdWb;
      end
    end
    return sel;
  endfunction

  always_comb begin
    forward_a = fwd_sel(ex_q.use_rs1, ex_q.rs1, ex_q.base.valid, mem_q, wb_q);
    forward_b = fwd_sel(ex_q.use_rs2, ex_q.rs2, ex_q.base.valid, mem_q, wb_q);
  end

  always_comb begin
    mem_d       = ex_q.base;
    mem_d.valid = ex_q.base.valid && !flush;

    ex_d                = '0;
    ex_d.base.valid     = id_valid;
    ex_d.base.rd        = id_rd;
    ex_d.base.reg_write = id_reg_write;
    ex_d.base.mem_read  = id_mem_read;
    ex_d.rs1            = id_rs1;
    ex_d.rs2            = id_rs2;
    ex_d.use_rs1        = id_use_rs1;
    ex_d.use_rs2        = id_use_rs2;
    if (flush || lu) begin
      ex_d.base.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else if (!dmem_busy) begin
      wb_q  <= mem_q;
      mem_q <= mem_d;
      ex_q  <= ex_d;
      if (count_en && !(&stall_count_q)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end

endmodule
